// File: rtl/simu_ram_pkg.sv
// Shared definitions for the simulation-RAM writer/reader pair: widths,
// the reader FSM state type, a shared address type and small helpers.
package simu_ram_pkg;

  localparam int SIMU_ADDR_W = 15;
  localparam int SIMU_DATA_W = 16;
  localparam int SIMU_WC_W   = 16;

  // One address type so the writer's final address and the reader's end
  // address are declared identically.
  typedef logic [SIMU_ADDR_W-1:0] simu_addr_t;

  typedef enum logic [2:0] {
    RD_IDLE = 3'd0,
    RD_REQ  = 3'd1,
    RD_WAIT = 3'd2,
    RD_HOLD = 3'd3,
    RD_FIN  = 3'd4
  } simu_rd_state_e;

  // Word counter increment that sticks at all-ones instead of wrapping.
  function automatic logic [SIMU_WC_W-1:0] sat_inc16(input logic [SIMU_WC_W-1:0] v);
    logic [SIMU_WC_W-1:0] r;
    if (v == 16'hFFFF) begin
      r = v;
    end else begin
      r = v + 16'd1;
    end
    return r;
  endfunction

endpackage

// File: rtl/simu_ram_rd_lat_pipe.sv
// RD_LAT-deep shift of the RAM read strobe. The last stage is high in the
// cycle the RAM returns data for the strobe issued RD_LAT cycles earlier.
// A flush drops anything in flight so an aborted read cannot resurface.
module simu_ram_rd_lat_pipe #(
  parameter int RD_LAT = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic flush,
  input  logic req,
  output logic data_vld
);

  logic [RD_LAT-1:0] shift_r;

  generate
    if (RD_LAT == 1) begin : g_one
      // Single-stage delay of the request strobe.
      always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
          shift_r <= 1'b0;
        end else if (flush) begin
          shift_r <= 1'b0;
        end else begin
          shift_r <= req;
        end
      end
    end else begin : g_multi
      // Multi-stage delay line of the request strobe.
      always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
          shift_r <= {RD_LAT{1'b0}};
        end else if (flush) begin
          shift_r <= {RD_LAT{1'b0}};
        end else begin
          shift_r <= {shift_r[RD_LAT-2:0], req};
        end
      end
    end
  endgenerate

  assign data_vld = shift_r[RD_LAT-1];

endmodule

// File: rtl/simu_ram_reader.sv
// Read side of the simulation RAM: on start, walks addresses 1..end_addr,
// one outstanding read at a time, and presents each word on a valid/ready
// stream. Abort ends the run early; done pulses once per run.
module simu_ram_reader
  import simu_ram_pkg::*;
#(
  parameter int ADDR_W = SIMU_ADDR_W,
  parameter int DATA_W = SIMU_DATA_W,
  parameter int RD_LAT = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              abort,
  input  logic [ADDR_W-1:0] end_addr,
  output logic              ram_rd_req,
  output logic [ADDR_W-1:0] ram_rd_addr,
  input  logic [DATA_W-1:0] ram_rd_data,
  output logic [DATA_W-1:0] out_data,
  output logic [ADDR_W-1:0] out_addr,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              busy,
  output logic              done,
  output logic [15:0]       word_count
);

  simu_rd_state_e    state_r, state_nx_s;
  logic              ram_rd_req_r, req_nx_s;
  logic [ADDR_W-1:0] ram_rd_addr_r, addr_nx_s;
  logic [DATA_W-1:0] out_data_r, data_nx_s;
  logic [ADDR_W-1:0] out_addr_r, oaddr_nx_s;
  logic              out_valid_r, valid_nx_s;
  logic              busy_r, busy_nx_s;
  logic              done_r, done_nx_s;
  logic [15:0]       word_count_r, wc_nx_s;
  logic [ADDR_W-1:0] end_q_r, end_nx_s;
  logic              flush_s;
  logic              lat_vld_s;

  // Data-valid strobe: the registered request delayed by the RAM latency.
  simu_ram_rd_lat_pipe #(
    .RD_LAT (RD_LAT)
  ) u_lat_pipe (
    .clk      (clk),
    .reset    (reset),
    .flush    (flush_s),
    .req      (ram_rd_req_r),
    .data_vld (lat_vld_s)
  );

  // Next-state and next-output decode; every output register is loaded
  // from here so the ports stay registered. Entering REQ raises the read
  // strobe for that one cycle, entering FIN raises done for that one cycle.
  always_comb begin
    state_nx_s = state_r;
    req_nx_s   = 1'b0;
    addr_nx_s  = ram_rd_addr_r;
    data_nx_s  = out_data_r;
    oaddr_nx_s = out_addr_r;
    valid_nx_s = out_valid_r;
    busy_nx_s  = busy_r;
    done_nx_s  = 1'b0;
    wc_nx_s    = word_count_r;
    end_nx_s   = end_q_r;
    flush_s    = 1'b0;
    case (state_r)
      RD_IDLE: begin
        // abort is meaningless here; start always takes precedence.
        if (start) begin
          end_nx_s  = end_addr;
          wc_nx_s   = 16'd0;
          busy_nx_s = 1'b1;
          if (end_addr == {ADDR_W{1'b0}}) begin
            state_nx_s = RD_FIN;
            done_nx_s  = 1'b1;
          end else begin
            addr_nx_s  = ADDR_W'(1);
            state_nx_s = RD_REQ;
            req_nx_s   = 1'b1;
          end
        end else begin
          state_nx_s = RD_IDLE;
        end
      end
      RD_REQ: begin
        if (abort) begin
          state_nx_s = RD_FIN;
          done_nx_s  = 1'b1;
          flush_s    = 1'b1;
        end else begin
          state_nx_s = RD_WAIT;
        end
      end
      RD_WAIT: begin
        if (abort) begin
          state_nx_s = RD_FIN;
          done_nx_s  = 1'b1;
          flush_s    = 1'b1;
        end else if (lat_vld_s) begin
          data_nx_s  = ram_rd_data;
          oaddr_nx_s = ram_rd_addr_r;
          valid_nx_s = 1'b1;
          state_nx_s = RD_HOLD;
        end else begin
          state_nx_s = RD_WAIT;
        end
      end
      RD_HOLD: begin
        // An abort in the accept cycle wins: the word is dropped uncounted.
        if (abort) begin
          valid_nx_s = 1'b0;
          state_nx_s = RD_FIN;
          done_nx_s  = 1'b1;
          flush_s    = 1'b1;
        end else if (out_ready) begin
          valid_nx_s = 1'b0;
          wc_nx_s    = sat_inc16(word_count_r);
          // Equality stop: the address never steps past end_q, so no wrap.
          if (ram_rd_addr_r == end_q_r) begin
            state_nx_s = RD_FIN;
            done_nx_s  = 1'b1;
          end else begin
            addr_nx_s  = ram_rd_addr_r + ADDR_W'(1);
            state_nx_s = RD_REQ;
            req_nx_s   = 1'b1;
          end
        end else begin
          state_nx_s = RD_HOLD;
        end
      end
      RD_FIN: begin
        busy_nx_s  = 1'b0;
        state_nx_s = RD_IDLE;
      end
      default: begin
        valid_nx_s = 1'b0;
        busy_nx_s  = 1'b0;
        flush_s    = 1'b1;
        state_nx_s = RD_IDLE;
      end
    endcase
  end

  // State and output registers; async reset clears the whole run.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r       <= RD_IDLE;
      ram_rd_req_r  <= 1'b0;
      ram_rd_addr_r <= {ADDR_W{1'b0}};
      out_data_r    <= {DATA_W{1'b0}};
      out_addr_r    <= {ADDR_W{1'b0}};
      out_valid_r   <= 1'b0;
      busy_r        <= 1'b0;
      done_r        <= 1'b0;
      word_count_r  <= 16'd0;
      end_q_r       <= {ADDR_W{1'b0}};
    end else begin
      state_r       <= state_nx_s;
      ram_rd_req_r  <= req_nx_s;
      ram_rd_addr_r <= addr_nx_s;
      out_data_r    <= data_nx_s;
      out_addr_r    <= oaddr_nx_s;
      out_valid_r   <= valid_nx_s;
      busy_r        <= busy_nx_s;
      done_r        <= done_nx_s;
      word_count_r  <= wc_nx_s;
      end_q_r       <= end_nx_s;
    end
  end

  assign ram_rd_req  = ram_rd_req_r;
  assign ram_rd_addr = ram_rd_addr_r;
  assign out_data    = out_data_r;
  assign out_addr    = out_addr_r;
  assign out_valid   = out_valid_r;
  assign busy        = busy_r;
  assign done        = done_r;
  assign word_count  = word_count_r;

endmodule

// File: tb/tb_simu_ram_reader.sv
// Bench for simu_ram_reader: a timeline model of a readout run is checked
// against the DUT every cycle, directed scenarios pin the model with
// hand-computed values, and a random phase mixes start/abort/back-pressure.
// A second small instance (4-bit address, RD_LAT=1) reads up to the top
// address to show the walk stops without wrapping.
module tb_simu_ram_reader;

  localparam int ADDR_W = 15;
  localparam int DATA_W = 16;
  localparam int RD_LAT = 2;

  logic              clk;
  logic              reset;
  logic              start;
  logic              abort;
  logic [ADDR_W-1:0] end_addr;
  logic              ram_rd_req;
  logic [ADDR_W-1:0] ram_rd_addr;
  logic [DATA_W-1:0] ram_rd_data;
  logic [DATA_W-1:0] out_data;
  logic [ADDR_W-1:0] out_addr;
  logic              out_valid;
  logic              out_ready;
  logic              busy;
  logic              done;
  logic [15:0]       word_count;

  // small instance
  logic        s_start, s_abort, s_req, s_valid, s_ready, s_busy, s_done;
  logic [3:0]  s_end, s_addr, s_oaddr;
  logic [15:0] s_rdata, s_odata, s_wc;

  int checks;
  int errors;

  simu_ram_reader #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .RD_LAT(RD_LAT)) dut (
    .clk(clk), .reset(reset), .start(start), .abort(abort), .end_addr(end_addr),
    .ram_rd_req(ram_rd_req), .ram_rd_addr(ram_rd_addr), .ram_rd_data(ram_rd_data),
    .out_data(out_data), .out_addr(out_addr), .out_valid(out_valid),
    .out_ready(out_ready), .busy(busy), .done(done), .word_count(word_count)
  );

  simu_ram_reader #(.ADDR_W(4), .DATA_W(16), .RD_LAT(1)) dut_small (
    .clk(clk), .reset(reset), .start(s_start), .abort(s_abort), .end_addr(s_end),
    .ram_rd_req(s_req), .ram_rd_addr(s_addr), .ram_rd_data(s_rdata),
    .out_data(s_odata), .out_addr(s_oaddr), .out_valid(s_valid),
    .out_ready(s_ready), .busy(s_busy), .done(s_done), .word_count(s_wc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // RAM contents as a pure function of address.
  function automatic logic [15:0] mem_fn(input logic [31:0] a);
    logic [31:0] h;
    h = (a * 32'd40503) ^ 32'h00005A3C;
    return h[15:0] ^ h[31:16];
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // ---------------- RAM models ----------------
  logic              rq_pipe [RD_LAT];
  logic [ADDR_W-1:0] ad_pipe [RD_LAT];
  logic [15:0]       junk_r;

  always @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i < RD_LAT; i++) begin
        rq_pipe[i] <= 1'b0;
        ad_pipe[i] <= '0;
      end
    end else begin
      rq_pipe[0] <= ram_rd_req;
      ad_pipe[0] <= ram_rd_addr;
      for (int i = 1; i < RD_LAT; i++) begin
        rq_pipe[i] <= rq_pipe[i-1];
        ad_pipe[i] <= ad_pipe[i-1];
      end
    end
    junk_r <= 16'($urandom) | 16'h0001;
  end

  // Outside the valid slot the bus carries a value guaranteed to differ.
  assign ram_rd_data = rq_pipe[RD_LAT-1] ? mem_fn(32'(ad_pipe[RD_LAT-1]))
                                         : (mem_fn(32'(ad_pipe[RD_LAT-1])) ^ junk_r);

  always @(posedge clk) begin
    s_rdata <= s_req ? mem_fn(32'(s_addr)) : ~mem_fn(32'(s_addr));
  end

  // ---------------- reference model ----------------
  // m_act: run in progress; m_fin: this is the done cycle; m_t: cycles
  // since the current word's request; m_hold: current word is presented.
  bit                m_act, m_fin, m_hold;
  int                m_t;
  logic [ADDR_W-1:0] m_cur, m_end;
  logic [15:0]       m_wc;

  int                done_cnt, req_cnt;
  logic [ADDR_W-1:0] acc_q[$];

  always @(negedge clk) begin
    if (!reset) begin
      chk("rst_req",   32'(ram_rd_req), 32'd0);
      chk("rst_addr",  32'(ram_rd_addr), 32'd0);
      chk("rst_data",  32'(out_data), 32'd0);
      chk("rst_oaddr", 32'(out_addr), 32'd0);
      chk("rst_valid", 32'(out_valid), 32'd0);
      chk("rst_busy",  32'(busy), 32'd0);
      chk("rst_done",  32'(done), 32'd0);
      chk("rst_wc",    32'(word_count), 32'd0);
      m_act  <= 1'b0;
      m_fin  <= 1'b0;
      m_hold <= 1'b0;
      m_t    <= 0;
      m_cur  <= '0;
      m_end  <= '0;
      m_wc   <= 16'd0;
    end else begin
      chk("req",     32'(ram_rd_req), 32'(m_act && !m_hold && (m_t == 0)));
      chk("rd_addr", 32'(ram_rd_addr), 32'(m_cur));
      chk("valid",   32'(out_valid), 32'(m_hold));
      if (m_hold) begin
        chk("out_data", 32'(out_data), 32'(mem_fn(32'(m_cur))));
        chk("out_addr", 32'(out_addr), 32'(m_cur));
      end
      chk("busy", 32'(busy), 32'(m_act || m_fin));
      chk("done", 32'(done), 32'(m_fin));
      chk("wc",   32'(word_count), 32'(m_wc));

      if (out_valid && out_ready && !abort) acc_q.push_back(out_addr);
      if (done) done_cnt <= done_cnt + 1;
      if (ram_rd_req) req_cnt <= req_cnt + 1;

      if (m_fin) begin
        m_fin <= 1'b0;
      end else if (!m_act) begin
        if (start) begin
          m_end <= end_addr;
          m_wc  <= 16'd0;
          if (end_addr == '0) begin
            m_fin <= 1'b1;
          end else begin
            m_act  <= 1'b1;
            m_cur  <= ADDR_W'(1);
            m_t    <= 0;
            m_hold <= 1'b0;
          end
        end
      end else if (abort) begin
        m_act  <= 1'b0;
        m_fin  <= 1'b1;
        m_hold <= 1'b0;
      end else if (m_hold) begin
        if (out_ready) begin
          m_hold <= 1'b0;
          m_wc   <= (m_wc == 16'hFFFF) ? m_wc : m_wc + 16'd1;
          if (m_cur == m_end) begin
            m_act <= 1'b0;
            m_fin <= 1'b1;
          end else begin
            m_cur <= m_cur + ADDR_W'(1);
            m_t   <= 0;
          end
        end
      end else if (m_t == RD_LAT) begin
        m_hold <= 1'b1;
      end else begin
        m_t <= m_t + 1;
      end
    end
  end

  // Small-instance monitor.
  logic [3:0] s_acc[$];
  int         s_bad, s_done_cnt;

  always @(negedge clk) begin
    if (reset) begin
      if (s_valid && s_ready) begin
        s_acc.push_back(s_oaddr);
        if (s_odata !== mem_fn(32'(s_oaddr))) s_bad <= s_bad + 1;
      end
      if (s_done) s_done_cnt <= s_done_cnt + 1;
    end
  end

  // ---------------- stimulus ----------------
  task automatic wait_done(input int budget, input string name);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < budget && !seen; i++) begin
      step();
      if (done) seen = 1'b1;
    end
    chk(name, 32'(seen), 32'd1);
  endtask

  task automatic pulse_start(input logic [ADDR_W-1:0] ea);
    end_addr = ea;
    start    = 1'b1;
    step();
    start    = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int base_acc, base_done, base_req, n;
    checks = 0; errors = 0; done_cnt = 0; req_cnt = 0; s_bad = 0; s_done_cnt = 0;
    reset = 1'b0; start = 1'b0; abort = 1'b0; end_addr = '0; out_ready = 1'b1;
    s_start = 1'b0; s_abort = 1'b0; s_end = 4'd15; s_ready = 1'b1;
    repeat (3) step();
    reset = 1'b1;
    step();

    // T1: five words, ready always high.
    base_acc = acc_q.size(); base_done = done_cnt; base_req = req_cnt;
    pulse_start(15'd5);
    n = 1;
    while (!out_valid && n < 20) begin step(); n++; end
    chk("t1_first_lat", 32'(n), 32'd4);
    wait_done(100, "t1_done_timeout");
    step(); step();
    chk("t1_words", 32'(acc_q.size() - base_acc), 32'd5);
    for (int k = 0; k < 5 && base_acc + k < acc_q.size(); k++)
      chk("t1_addr_seq", 32'(acc_q[base_acc + k]), 32'(k + 1));
    chk("t1_wc",    32'(word_count), 32'd5);
    chk("t1_dones", 32'(done_cnt - base_done), 32'd1);
    chk("t1_reqs",  32'(req_cnt - base_req), 32'd5);
    chk("t1_busy",  32'(busy), 32'd0);
    chk("t1_last_addr", 32'(ram_rd_addr), 32'd5);

    // T2: empty run.
    base_done = done_cnt; base_req = req_cnt;
    pulse_start(15'd0);
    chk("t2_done_lat", 32'(done), 32'd1);
    step(); step();
    chk("t2_reqs",  32'(req_cnt - base_req), 32'd0);
    chk("t2_wc",    32'(word_count), 32'd0);
    chk("t2_dones", 32'(done_cnt - base_done), 32'd1);
    chk("t2_busy",  32'(busy), 32'd0);

    // T3: back-pressure on word 2.
    base_acc = acc_q.size();
    pulse_start(15'd3);
    n = 0;
    while (acc_q.size() - base_acc < 1 && n < 50) begin step(); n++; end
    out_ready = 1'b0;
    n = 0;
    while (!out_valid && n < 20) begin step(); n++; end
    chk("t3_hold_addr", 32'(out_addr), 32'd2);
    base_req = req_cnt;
    for (int k = 0; k < 10; k++) begin
      chk("t3_stable_addr",  32'(out_addr), 32'd2);
      chk("t3_stable_data",  32'(out_data), 32'(mem_fn(32'd2)));
      chk("t3_stable_valid", 32'(out_valid), 32'd1);
      step();
    end
    chk("t3_no_req", 32'(req_cnt - base_req), 32'd0);
    out_ready = 1'b1;
    wait_done(100, "t3_done_timeout");
    step();
    chk("t3_wc", 32'(word_count), 32'd3);

    // T4: abort while word 7 is held.
    base_acc = acc_q.size();
    pulse_start(15'd100);
    n = 0;
    while (acc_q.size() - base_acc < 6 && n < 100) begin step(); n++; end
    out_ready = 1'b0;
    n = 0;
    while (!out_valid && n < 20) begin step(); n++; end
    chk("t4_hold_addr", 32'(out_addr), 32'd7);
    abort = 1'b1;
    step();
    abort = 1'b0;
    chk("t4_valid_drop", 32'(out_valid), 32'd0);
    chk("t4_done", 32'(done), 32'd1);
    step();
    chk("t4_busy", 32'(busy), 32'd0);
    chk("t4_wc",   32'(word_count), 32'd6);
    chk("t4_words", 32'(acc_q.size() - base_acc), 32'd6);
    out_ready = 1'b1;
    step();

    // T5: start while busy, then async reset mid-WAIT, then a fresh run.
    pulse_start(15'd20);
    pulse_start(15'd9);
    chk("t5_busy_before", 32'(busy), 32'd1);
    chk("t5_addr_before", 32'(ram_rd_addr), 32'd1);
    #2;
    reset = 1'b0;
    #1;
    chk("t5_async_busy",  32'(busy), 32'd0);
    chk("t5_async_addr",  32'(ram_rd_addr), 32'd0);
    chk("t5_async_req",   32'(ram_rd_req), 32'd0);
    chk("t5_async_valid", 32'(out_valid), 32'd0);
    step();
    reset = 1'b1;
    step();
    base_acc = acc_q.size();
    pulse_start(15'd4);
    wait_done(100, "t5_done_timeout");
    step();
    chk("t5_wc", 32'(word_count), 32'd4);
    chk("t5_words", 32'(acc_q.size() - base_acc), 32'd4);

    // T6: small instance walks to its top address.
    s_start = 1'b1;
    step();
    s_start = 1'b0;
    n = 0;
    while (!s_done && n < 200) begin step(); n++; end
    chk("t6_done_timeout", 32'(s_done), 32'd1);
    step(); step();
    chk("t6_words", 32'(s_acc.size()), 32'd15);
    for (int k = 0; k < s_acc.size(); k++)
      chk("t6_addr_seq", 32'(s_acc[k]), 32'(k + 1));
    chk("t6_bad_data", 32'(s_bad), 32'd0);
    chk("t6_wc",       32'(s_wc), 32'd15);
    chk("t6_dones",    32'(s_done_cnt), 32'd1);
    chk("t6_last_addr", 32'(s_addr), 32'd15);

    // Random phase.
    for (int i = 0; i < 3000; i++) begin
      out_ready = ($urandom_range(0, 99) < 75);
      abort     = ($urandom_range(0, 99) < 3);
      end_addr  = 15'($urandom_range(0, 30));
      start     = busy ? ($urandom_range(0, 99) < 5) : ($urandom_range(0, 99) < 40);
      step();
    end
    start = 1'b0; abort = 1'b0; out_ready = 1'b1;
    n = 0;
    while (busy && n < 300) begin step(); n++; end
    chk("rand_idle_timeout", 32'(busy), 32'd0);
    step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/simu_ram_reader.md
Name: simu_ram_reader

Overview:
- Read-side companion of the trigger-driven simulation-RAM writer.
- On a start pulse it walks the simulation RAM from address 1 up to a latched end address, which is the writer's last write address.
- It returns each word on a valid/ready output stream toward the readout/DAQ path.
- One read is outstanding at a time; the RAM read latency is fixed and set by a parameter.

Parameters:
ADDR_W, 15, simulation RAM address width (matches writer address)
DATA_W, 16, RAM word width
RD_LAT, 2, cycles from ram_rd_req to ram_rd_data valid (legal 1..4)

Ports:
clk  input  1  system clock, all logic on rising edge
reset  input  1  asynchronous, active-low reset
start  input  1  one-cycle pulse; begins readout when idle
abort  input  1  one-cycle pulse; terminates readout
end_addr  input  ADDR_W  last written address (writer's final address), sampled on accepted start
ram_rd_req  output  1  read strobe to simulation RAM
ram_rd_addr  output  ADDR_W  read address
ram_rd_data  input  DATA_W  RAM read data, valid RD_LAT cycles after ram_rd_req
out_data  output  DATA_W  stream data
out_addr  output  ADDR_W  address the out_data word came from
out_valid  output  1  stream valid
out_ready  input  1  downstream ready
busy  output  1  high from accepted start until done
done  output  1  one-cycle pulse at completion or abort
word_count  output  16  words transferred in current/last run

Behaviour:
- Reset (reset=0, async): state IDLE; ram_rd_req=0, ram_rd_addr=0, out_data=0, out_addr=0, out_valid=0, busy=0, done=0, word_count=0. Outputs change on the first clk edge after release.
- FSM states IDLE, REQ, WAIT, HOLD, FIN.
- IDLE, start=1:
  - latch end_addr into end_q;
  - word_count<=0; busy<=1;
  - if end_addr==0, go to FIN (empty run);
  - otherwise ram_rd_addr<=1 and go to REQ.
- REQ: ram_rd_req=1 for exactly this one cycle; a latency counter loads RD_LAT; go to WAIT.
- WAIT: latency counter decrements. In the cycle ram_rd_data is valid (RD_LAT cycles after the REQ cycle):
  - capture out_data<=ram_rd_data and out_addr<=ram_rd_addr;
  - out_valid<=1;
  - go to HOLD.
- HOLD:
  - out_data, out_addr and out_valid are held stable while out_ready=0.
  - On out_valid&&out_ready:
    - out_valid<=0; word_count<=word_count+1 (saturates at 16'hFFFF);
    - if ram_rd_addr==end_q, go to FIN;
    - otherwise ram_rd_addr<=ram_rd_addr+1 and go to REQ.
- FIN: done=1 for one cycle, busy<=0, go to IDLE. ram_rd_addr keeps its last value. word_count holds until the next start.
- Throughput: at most one word per RD_LAT+2 cycles. Latency from start to first out_valid is RD_LAT+2 cycles.
- Address arithmetic:
  - termination is by equality with end_q, so the address never wraps;
  - end_addr = 2^ADDR_W-1 reads 32767 words and stops;
  - end_addr changing while busy has no effect.
- start while busy (including in FIN) is ignored.
- abort in any non-IDLE state:
  - the next state is FIN;
  - out_valid<=0 at once, even if not yet accepted; word_count is not incremented;
  - any in-flight RAM data is discarded.
- abort and an accept in the same cycle: abort wins; the word is not counted.
- abort in IDLE: no effect; no done pulse.
- Simultaneous start and abort in IDLE: start is accepted, abort ignored.
- Reset mid-run returns everything to the reset values immediately.

Decomposition:
- Shared package simu_ram_pkg:
  - constants SIMU_ADDR_W=15, SIMU_DATA_W=16;
  - FSM state enum (IDLE, REQ, WAIT, HOLD, FIN);
  - typedef for the address type, so writer and reader share one definition.
- One sub-module, simu_ram_rd_lat_pipe: an RD_LAT-deep shift of the request strobe. It produces the data-valid strobe and replaces the counter. Use it if RD_LAT timing is reused elsewhere; otherwise keep it inline.

Test Plan:
- end_addr=5, start pulse, out_ready=1:
  - ram_rd_addr sequence is 1,2,3,4,5;
  - five out_valid beats with out_addr 1..5 and the matching RAM contents;
  - done once; word_count=5; first out_valid 4 cycles after start (RD_LAT=2).
- end_addr=0, start -> no ram_rd_req, done pulse 1 cycle after start, word_count=0.
- end_addr=3, out_ready held low 10 cycles on word 2 -> out_data/out_addr stay stable with no new ram_rd_req; then completes with word_count=3.
- end_addr=100, abort during HOLD of word 7 -> out_valid drops the next cycle; done pulses; word_count=6; busy=0.
- Second start pulse while busy, then reset=0 asserted mid-WAIT -> second start ignored; all outputs go to reset values asynchronously; a fresh start after release works normally.
- end_addr=32767, RD_LAT=1 -> last ram_rd_addr is 32767 with no wrap to 0; word_count=32767; done once.
